// File: rtl/tt_um_tdm_demux_1x2.sv
// Time-division 1-to-2 demultiplexer: one serial pin carries two interleaved
// 4-bit channels (A on even slots, B on odd slots, MSB first) framed by a
// sync marker on slot 0. Completed frames are published to uo_out as {B, A}.
module tt_um_tdm_demux_1x2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  logic       din, sync, bit_en;
  state_t     state, next_state;
  logic [2:0] slot, next_slot;
  logic       start, shift, done, abort;
  logic [3:0] shreg_a, shreg_b;
  logic [7:0] frame_out;
  logic       frame_valid, sync_err, busy;
  logic [4:0] frame_cnt;

  assign din    = ui_in[0];
  assign sync   = ui_in[1];
  assign bit_en = ui_in[2];

  // Pins the tile exposes but this block has no use for.
  logic unused_pins;
  assign unused_pins = &{ena, uio_in, ui_in[7:3], 1'b0};

  // State and slot counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      slot  <= 3'd0;
    end else begin
      state <= next_state;
      slot  <= next_slot;
    end
  end

  // Next-state logic; also decodes what the datapath does with this slot.
  // A sync bit always starts a fresh frame, whether from IDLE or as an abort
  // of a frame in progress.
  always_comb begin
    next_state = state;
    next_slot  = slot;
    start      = 1'b0;
    shift      = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (sync) begin
            next_state = RECV;
            next_slot  = 3'd1;
            start      = 1'b1;
          end
        end
        RECV: begin
          if (sync) begin
            abort     = 1'b1;
            start     = 1'b1;
            next_slot = 3'd1;
          end else if (slot == 3'd7) begin
            done       = 1'b1;
            next_state = IDLE;
            next_slot  = 3'd0;
          end else begin
            shift     = 1'b1;
            next_slot = slot + 3'd1;
          end
        end
        default: begin
          next_state = IDLE;
          next_slot  = 3'd0;
        end
      endcase
    end
  end

  // Moore output: busy while a frame is being received.
  always_comb begin
    busy = (state == RECV);
  end

  // Datapath: shift registers, published frame, status flags and counter.
  // The slot-7 bit is B[0], so it is merged directly into the published
  // value instead of waiting one more cycle for shreg_b.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_a     <= 4'h0;
      shreg_b     <= 4'h0;
      frame_out   <= 8'h00;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      frame_cnt   <= 5'd0;
    end else begin
      frame_valid <= done;
      if (abort) sync_err <= 1'b1;
      if (start) begin
        shreg_a <= {3'b000, din};
        shreg_b <= 4'h0;
      end else if (shift) begin
        if (slot[0]) shreg_b <= {shreg_b[2:0], din};
        else         shreg_a <= {shreg_a[2:0], din};
      end
      if (done) begin
        frame_out <= {shreg_b[2:0], din, shreg_a};
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end

  assign uo_out  = frame_out;
  assign uio_out = {frame_cnt, busy, sync_err, frame_valid};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_tdm_demux_1x2.sv
// Directed bench for the TDM demux; expected frame results are queued when
// the completing slot is driven and checked when the DUT publishes them.
module tb_tt_um_tdm_demux_1x2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_tdm_demux_1x2 dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_fail = 0;

  // reference model state
  logic [7:0] m_uo  = 8'h00;
  logic [4:0] m_cnt = 5'd0;
  logic       m_err = 1'b0;

  function automatic logic [7:0] m_uio(input logic busy, input logic fv);
    return {m_cnt, busy, m_err, fv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic d, input logic s, input logic en);
    ui_in = {5'($urandom), en, s, d};
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      ui_in = 8'($urandom);
      tick();
    end
    m_uo = 8'h00; m_cnt = 5'd0; m_err = 1'b0;
    sbq.delete();
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;
  endtask

  // Send a full frame; slot 0 carries sync. stall = idle cycles after each slot.
  task automatic send_frame(input logic [3:0] a, input logic [3:0] b, input int stall);
    logic bitv;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      bitv = (i % 2 == 0) ? a[3 - i/2] : b[3 - i/2];
      drive(bitv, i == 0, 1'b1);
      if (i == 7) begin
        m_uo  = {b, a};
        m_cnt = m_cnt + 5'd1;
        e.uo  = m_uo;
        e.uio = m_uio(1'b0, 1'b1);
        sbq.push_back(e);
      end
      tick();
      if (i < 7) begin
        chk("mid_uo", uo_out, m_uo);
        chk("mid_uio", uio_out, m_uio(1'b1, 1'b0));
        for (int k = 0; k < stall; k++) begin
          drive(1'($urandom), 1'($urandom), 1'b0);
          tick();
          chk("stall_uo", uo_out, m_uo);
          chk("stall_uio", uio_out, m_uio(1'b1, 1'b0));
        end
      end else begin
        if (sbq.size() == 0) begin
          n_vec++; n_fail++;
          $error("FAIL sb_empty: observed 0 entries expected 1");
        end else begin
          e = sbq.pop_front();
          chk("done_uo", uo_out, e.uo);
          chk("done_uio", uio_out, e.uio);
        end
      end
    end
  endtask

  task automatic idle_check(input string tag);
    drive(1'($urandom), 1'($urandom), 1'b0);
    tick();
    chk(tag, uio_out, m_uio(1'b0, 1'b0));
    chk(tag, uo_out, m_uo);
  endtask

  initial begin
    // reset with random inputs, then idle
    do_reset(2);
    for (int i = 0; i < 3; i++) idle_check("post_rst_idle");
    // bit_en with no sync in IDLE is ignored
    drive(1'b1, 1'b0, 1'b1); tick();
    chk("idle_nosync", uio_out, m_uio(1'b0, 1'b0));

    // single frame A=0xA B=0x5
    send_frame(4'hA, 4'h5, 0);
    chk("single_uo", uo_out, 8'h5A);
    chk("single_uio", uio_out, 8'h09);
    idle_check("single_after");
    chk("single_after_uio", uio_out, 8'h08);

    // stalled frame
    do_reset(1);
    send_frame(4'hA, 4'h5, 3);
    chk("stall_final", uo_out, 8'h5A);
    idle_check("stall_after");

    // mid-frame sync: 3 slots, then a new frame A=0x3 B=0xC
    do_reset(1);
    drive(1'b1, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b1); tick();
    chk("abort_pre_err", uio_out, m_uio(1'b1, 1'b0));
    m_err = 1'b1;
    send_frame(4'h3, 4'hC, 0);
    chk("abort_uo", uo_out, 8'hC3);
    chk("abort_uio", uio_out, 8'h0B);
    idle_check("abort_after");

    // 32 back-to-back frames: counter wraps to 0
    do_reset(1);
    for (int f = 1; f <= 32; f++) begin
      send_frame(4'(f), 4'(~f), 0);
      if (f == 31) chk("wrap_31", uio_out[7:3], 8'd31);
      if (f == 32) chk("wrap_0", uio_out, 8'h01);
    end
    idle_check("wrap_after");

    // reset mid-frame, then a full frame A=0xF B=0x0
    do_reset(1);
    send_frame(4'h1, 4'h2, 0);
    drive(1'b1, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    do_reset(1);
    send_frame(4'hF, 4'h0, 0);
    chk("rstmid_uo", uo_out, 8'h0F);
    chk("rstmid_uio", uio_out, 8'h09);
    idle_check("rstmid_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_tdm_demux_1x2.md
# tt_um_tdm_demux_1x2

Receive-side counterpart of our 2:1 select mux: a time-division 1-to-2 demultiplexer for a TinyTapeout tile. A single serial data pin carries two interleaved 4-bit channels, A and B, framed by a sync marker. The block steers alternating bit slots into per-channel shift registers and publishes both nibbles together once a frame completes. It also reports a frame-valid pulse, a sticky sync-error flag, a busy flag and a wrapping frame counter.

## Interface
Parameters:
- none; frame is fixed at 8 slots, 4 bits per channel.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- ena  input  1  ignored.
- ui_in  input  8  bit 0 = din (serial data); bit 1 = sync (frame marker); bit 2 = bit_en (slot qualifier); bits 7:3 unused. All bits are synchronous to clk.
- uo_out  output  8  bits 3:0 = channel A nibble; bits 7:4 = channel B nibble; both registered.
- uio_in  input  8  unused.
- uio_out  output  8  bit 0 = frame_valid; bit 1 = sync_err; bit 2 = busy; bits 7:3 = frame_cnt (5-bit).
- uio_oe  output  8  constant 8'hFF.

## Operation
- A slot is consumed on any rising edge where bit_en = 1. din and sync are ignored when bit_en = 0.
- Slot order is MSB-first and interleaved. Slot 0 = A[3], 1 = B[3], 2 = A[2], 3 = B[2], 4 = A[1], 5 = B[1], 6 = A[0], 7 = B[0].
- Even slots shift into shreg_a. Odd slots shift into shreg_b.
- FSM has two states, IDLE and RECV, plus a 3-bit slot counter.
  - IDLE, bit_en & sync: din is slot 0. Go to RECV with slot = 1.
  - IDLE, bit_en & !sync: ignored; no error.
  - RECV, bit_en & !sync: consume the slot; slot increments.
  - RECV, bit_en & sync: set sync_err (sticky). Discard the partial frame. Treat this bit as slot 0 of a new frame; slot = 1.
  - RECV, slot 7 consumed without sync:
    - copy {B, A} into uo_out;
    - pulse frame_valid;
    - increment frame_cnt;
    - return to IDLE.
- busy = 1 while in RECV.
- frame_cnt wraps 31 -> 0.
- sync_err is cleared only by reset.
- uo_out holds its last completed frame until the next completion. Partial frames never reach uo_out.
- Back-to-back frames need no gap. A sync-marked bit on the cycle after slot 7 starts the next frame from IDLE.

## Timing
- Reset: rst_n sampled low at an edge forces the following:
  - state = IDLE, slot = 0;
  - shift registers = 0;
  - uo_out = 8'h00;
  - uio_out = 8'h00;
  - uio_oe stays 8'hFF at all times.
- Reset mid-frame discards the partial frame. sync_err and frame_cnt also clear.
- Latency: the slot-7 bit is consumed at edge k. uo_out, frame_valid and frame_cnt all change at edge k, so they are visible during cycle k+1.
- frame_valid is exactly 1 cycle wide. The minimum spacing between pulses is 8 cycles.
- busy rises at the edge that consumes slot 0. It falls at the edge that consumes slot 7.
- Idle cycles (bit_en = 0) inside a frame stall it indefinitely. There is no timeout.
- A sync error and a restart happen in the same edge. frame_valid is not asserted for the aborted frame.

## Test plan
- Reset: hold rst_n low for 2 cycles, with ui_in random -> uo_out = 0x00, uio_out = 0x00, uio_oe = 0xFF. After release with bit_en = 0, all outputs stay unchanged.
- Single frame, A = 0xA, B = 0x5:
  - drive din slots 0..7 = 1,0,0,1,1,0,0,1, with sync = 1 on slot 0 only and bit_en = 1 for 8 consecutive cycles;
  - next cycle: uo_out = 0x5A and frame_valid = 1 for one cycle; frame_cnt = 1 (uio_out = 0x09, then 0x08); busy = 0.
- Stalled frame: same bits as above, with 3 bit_en = 0 cycles after each slot -> uo_out stays 0x00 until the final slot, then becomes 0x5A with a single pulse. busy = 1 throughout.
- Mid-frame sync: send 3 slots, then assert sync on the 4th bit and continue with 7 more slots encoding A = 0x3, B = 0xC -> sync_err = 1 from the 4th bit onward. No pulse for the aborted frame. uo_out = 0xC3 after the completing slot.
- Wrap: send 32 back-to-back frames with no gap -> frame_valid pulses every 8 cycles. frame_cnt reads 31 after frame 31 and 0 after frame 32. sync_err stays 0.
- Reset mid-frame: send 4 slots, pulse rst_n low for 1 cycle, then send a full frame A = 0xF, B = 0x0 -> outputs read 0 after reset. After the frame, uo_out = 0x0F and frame_cnt = 1.
